// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared widths, tap layout and legality helpers for win_kxk_gen
//
// Purpose : constant functions used by the window generator and its line
//           buffers. Nothing in here produces hardware by itself.
//   addr_w(depth)          bits needed to address 0..depth-1 (never below 1)
//   x_w(width), y_w(height) column / line counter widths
//   tap_lsb(r, c, k, dw)   LSB of tap (r,c) inside the flattened window
//   ksize_legal(k)         odd kernel side in the range 3..7

package win_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int x_w(input int img_width);
        return addr_w(img_width);
    endfunction

    function automatic int y_w(input int img_height);
        return addr_w(img_height);
    endfunction

    // r = 0 is the oldest line, c = 0 the oldest column.
    function automatic int tap_lsb(input int r, input int c, input int ksize, input int dw);
        return (r * ksize + c) * dw;
    endfunction

    function automatic bit ksize_legal(input int ksize);
        return (ksize >= 3) && (ksize <= 7) && ((ksize % 2) == 1);
    endfunction

endpackage

// File: rtl/win_line_buf.sv
// rtl/win_line_buf.sv - one line of pixel storage with registered read
//
// Purpose : DEPTH x DATA_WIDTH RAM holding one image line. The read is
//           registered and read-first: a read and write to the same address
//           on the same edge returns the previous contents. The chain in
//           win_kxk_gen reads a column on the pixel's own cycle and writes the
//           shifted-down value one cycle later, so each buffer sees one read
//           address and one (delayed) write address per pixel.
// Ports   :
//   clk      rising-edge clock
//   rd_en    capture mem[rd_addr] into rd_data
//   rd_addr  read column
//   rd_data  registered read data (held while rd_en is low)
//   wr_en    write wr_data at wr_addr
//   wr_addr  write column
//   wr_data  write data
// The RAM and its read register are intentionally not reset.

module win_line_buf
    import win_pkg::*;
#(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/win_kxk_gen.sv
// rtl/win_kxk_gen.sv - parametrised KxK sliding-window generator for raster pixel streams
//
// Purpose : turns a raster-order pixel stream into one flattened KSIZE x KSIZE
//           window per qualifying pixel, two clocks after that pixel.
// Config  : define WIN_EDGE_ZERO_EN to emit a window for every pixel, with taps
//           lying above row 0 or left of column 0 forced to zero. Without it
//           only fully interior windows are emitted.
// Ports   :
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   in_vld   pixel valid (no backpressure)
//   in_sof   first pixel of a frame, qualified by in_vld
//   in_data  pixel value
//   out_vld  one-cycle window strobe
//   out_sof  first window emitted since the last in_sof
//   out_eol  window produced by the last column of a line
//   out_win  tap (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH];
//            r = 0 oldest line, c = 0 oldest column, (KSIZE-1,KSIZE-1) newest
// Pipeline: stage 1 reads the line buffers and registers the pixel and its
//           coordinates; stage 2 shifts the window, masks and registers out.

module win_kxk_gen
    import win_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_vld,
    input  logic                              in_sof,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_vld,
    output logic                              out_sof,
    output logic                              out_eol,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] out_win
);

    localparam int X_W   = x_w(IMG_WIDTH);
    localparam int Y_W   = y_w(IMG_HEIGHT);
    localparam int NLB   = KSIZE - 1;
    localparam int WIN_W = KSIZE * KSIZE * DATA_WIDTH;

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    if (!ksize_legal(KSIZE) || (IMG_WIDTH < KSIZE) || (IMG_HEIGHT < KSIZE)) begin : g_bad_cfg
        $error("win_kxk_gen: KSIZE must be odd in 3..7 and not exceed the image size");
    end

    // ------------------------------------------------------------------
    // Raster position. in_sof overrides the running counters so a frame
    // can be re-synchronised at any pixel.
    // ------------------------------------------------------------------
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic [X_W-1:0] px_x;
    logic [Y_W-1:0] px_y;

    always_comb begin
        px_x = in_sof ? '0 : x_cnt;
        px_y = in_sof ? '0 : y_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_vld) begin
            if (px_x == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (px_y == Y_LAST) ? '0 : px_y + 1'b1;
            end else begin
                x_cnt <= px_x + 1'b1;
                y_cnt <= px_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: pixel, coordinates and frame marker, aligned with the
    // registered line buffer outputs.
    // ------------------------------------------------------------------
    logic                  s1_vld;
    logic                  s1_sof;
    logic [X_W-1:0]        s1_x;
    logic [Y_W-1:0]        s1_y;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_data <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_sof  <= in_sof;
                s1_x    <= px_x;
                s1_y    <= px_y;
                s1_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer chain. Buffer k holds, at column x, the pixel k+1 lines
    // above. Every buffer is read at the pixel's column on its own cycle;
    // one cycle later the value read from buffer k-1 (or the pixel itself
    // for k = 0) is written into buffer k at the same column, pushing each
    // line one buffer further down the chain.
    // ------------------------------------------------------------------
    logic [NLB-1:0][DATA_WIDTH-1:0] lb_q;

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        logic [DATA_WIDTH-1:0] wdata;

        if (k == 0) begin : g_head
            assign wdata = s1_data;
        end else begin : g_link
            assign wdata = lb_q[k-1];
        end

        win_line_buf #(
            .DEPTH      (IMG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (X_W)
        ) u_line_buf (
            .clk     (clk),
            .rd_en   (in_vld),
            .rd_addr (px_x),
            .rd_data (lb_q[k]),
            .wr_en   (s1_vld),
            .wr_addr (s1_x),
            .wr_data (wdata)
        );
    end

    // ------------------------------------------------------------------
    // Stage 2: shift the new vertical column in at c = KSIZE-1.
    // Window storage is indexed [column][row].
    // ------------------------------------------------------------------
    logic [KSIZE-1:0][DATA_WIDTH-1:0]            col_new;
    logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win_q;
    logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win_nxt;
    logic [WIN_W-1:0]                            win_flat;
    logic                                        emit;

    always_comb begin
        col_new          = '0;
        col_new[KSIZE-1] = s1_data;
        // Buffer k sits k+1 lines above the current pixel.
        for (int k = 0; k < NLB; k++) begin
            col_new[KSIZE-2-k] = lb_q[k];
        end
    end

    always_comb begin
        win_nxt          = win_q;
        win_nxt[KSIZE-1] = col_new;
        for (int c = 0; c < KSIZE - 1; c++) begin
            win_nxt[c] = win_q[c+1];
        end
    end

`ifdef WIN_EDGE_ZERO_EN
    // Every pixel produces a window; taps whose source lies above row 0 or
    // left of column 0 hold stale or previous-line data and are zeroed.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if ((int'(s1_y) >= KSIZE - 1 - r) && (int'(s1_x) >= KSIZE - 1 - c)) begin
                    win_flat[tap_lsb(r, c, KSIZE, DATA_WIDTH) +: DATA_WIDTH] = win_nxt[c][r];
                end
            end
        end
    end

    assign emit = s1_vld;
`else
    // Only fully interior windows are emitted, so no tap ever needs masking.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                win_flat[tap_lsb(r, c, KSIZE, DATA_WIDTH) +: DATA_WIDTH] = win_nxt[c][r];
            end
        end
    end

    assign emit = s1_vld && (s1_x >= X_W'(KSIZE - 1)) && (s1_y >= Y_W'(KSIZE - 1));
`endif

    // A frame start that does not itself emit a window is remembered until
    // the first window of that frame goes out.
    logic sof_pend;
    logic sof_hit;

    assign sof_hit = sof_pend | (s1_vld & s1_sof);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= '0;
            sof_pend <= 1'b0;
            out_vld  <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            out_win  <= '0;
        end else begin
            if (s1_vld) begin
                win_q <= win_nxt;
            end
            sof_pend <= emit ? 1'b0 : sof_hit;
            out_vld  <= emit;
            out_sof  <= emit & sof_hit;
            out_eol  <= emit & (s1_x == X_LAST);
            if (emit) begin
                out_win <= win_flat;
            end
        end
    end

endmodule

// File: doc/win_kxk_gen.md
# win_kxk_gen

Parametrised KxK sliding-window generator for raster-order pixel streams. Generalises the fixed 3x3 operator front end to any odd kernel size, image width and height, with frame-sync tracking, gap-tolerant valid handling and optional zero-padded border windows. Sits between the pixel source (camera/DMA unpacker) and KxK arithmetic kernels (Sobel, Gaussian, median). Consumers receive one flattened window per qualifying input pixel.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- KSIZE, 3, window side; odd, 3..7
- IMG_WIDTH, 640, pixels per line; >= KSIZE
- IMG_HEIGHT, 480, lines per frame; >= KSIZE
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_vld  in  1  in_data valid this cycle; no backpressure
- in_sof  in  1  qualifies the first pixel of a frame; ignored unless in_vld
- in_data  in  DATA_WIDTH  pixel, raster order
- out_vld  out  1  window valid, one-cycle pulse per window
- out_sof  out  1  first window of the frame
- out_eol  out  1  window ends at the last column of a line
- out_win  out  KSIZE*KSIZE*DATA_WIDTH  tap (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest line, c=0 the oldest column; tap (KSIZE-1,KSIZE-1) is the pixel that produced the window

## Operation
- Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance only on in_vld; x wraps to 0 and increments y; after (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0.
- in_vld with in_sof forces this pixel to (0,0) regardless of the counter state (mid-frame resync); subsequent pixels count from there.
- KSIZE-1 line buffers, each IMG_WIDTH deep, chained: buffer k outputs the pixel from the line k+1 lines above, at the same x. Read-before-write at address x on every in_vld.
- Window column register: on each valid pixel the KSIZE vertical taps (line buffer outputs plus in_data) shift into column KSIZE-1; older columns shift toward c=0.
- Window emitted (without WIN_EDGE_ZERO_EN) only when y >= KSIZE-1 and x >= KSIZE-1 at the producing pixel; otherwise no out_vld.
- out_sof asserted on the first emitted window after in_sof; out_eol when the producing x = IMG_WIDTH-1.
- Line buffer contents are not cleared at reset or frame start; stale data never reaches an emitted window because of the gating/masking above.
- No internal backpressure; downstream must accept every out_vld.

## Timing
- Reset values: out_vld=0, out_sof=0, out_eol=0, out_win=0; x=y=0; pipeline valids cleared. Line buffer RAM not reset.
- Latency: fixed 2 clk from in_vld (cycle T) to out_vld (T+2). Stage 1: line buffer read, register in_data/x/y/vld. Stage 2: window shift, mask, output register.
- Gaps: idle cycles between pixels do not shift the window or counters; the output for each pixel still appears exactly 2 clk after it.
- Back-to-back in_vld at full rate: one window per clk.
- rst mid-frame: all in-flight windows dropped; the next frame requires in_sof, otherwise counting resumes from (0,0).

## Configuration
- WIN_EDGE_ZERO_EN: when defined, every valid input pixel produces a window; taps whose source row y-(KSIZE-1-r) < 0 or column x-(KSIZE-1-c) < 0 output 0. The first window of a frame is all zero except tap (KSIZE-1,KSIZE-1). When undefined, only interior windows are emitted and no masking logic exists.

## Structure
- Package win_pkg: X_W = $clog2(IMG_WIDTH), Y_W = $clog2(IMG_HEIGHT) width functions, tap bit-offset function tap_lsb(r,c), KSIZE legality check.
- Sub-module win_line_buf: single-port-style read-first RAM, depth IMG_WIDTH, width DATA_WIDTH, registered read; instantiated KSIZE-1 times in a chain.

## Test plan
- KSIZE=3, IMG 8x6, pixel=y*8+x, continuous in_vld with in_sof on first: 24 windows; first at T+2 after pixel (2,2) with taps {0,1,2,8,9,10,16,17,18}, out_sof=1; out_eol on x=7 windows.
- Same stream with random 0-3 idle cycles between pixels: identical window sequence, each exactly 2 clk after its producing pixel.
- in_sof asserted at pixel (3,4) of frame 1: counters reset; no window until new (2,2); no frame-1 data in any tap.
- rst pulsed while out_vld active: all outputs 0 next edge; resumed frame with in_sof reproduces the first test.
- WIN_EDGE_ZERO_EN, KSIZE=5, IMG 8x6: 48 windows; pixel (1,0) window has only taps (4,3)=0 and (4,4)=1, rest 0.
- KSIZE=7, IMG_WIDTH=7: single window per line from row 6, center tap (3,3)=y*7+3-... matches reference model.
